stopwatch_time_core: RTL and testbench

- Consumer end of the 10 ms timebase interface. Samples the divided `clk_10ms` square wave in the `clk_50` domain and converts each rising edge into a single-cycle tick.
- Counts elapsed time in BCD: centiseconds, seconds and minutes.
- Drives `work` back to the divider so the timebase phase freezes while paused.
- A start/lap key FSM controls the block; outputs feed the seven-segment display driver.

---
 rtl/stopwatch_time_core.sv | 196 +++++++++++++++++++
 tb/tb_stopwatch_time_core.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_time_core.sv
// Stopwatch time core: turns the 10 ms timebase into single-cycle ticks,
// counts mm:ss.cc in BCD, and runs the start/lap key state machine.
// All outputs come straight from flops; nothing combinational reaches a pin.
module stopwatch_time_core #(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_MIN     = 59
) (
  input  logic       clk_50,
  input  logic       reset,
  input  logic       clk_10ms,
  input  logic       key_start_n,
  input  logic       key_lap_n,
  output logic       work,
  output logic [7:0] cs_bcd,
  output logic [7:0] sec_bcd,
  output logic [7:0] min_bcd,
  output logic       lap_active,
  output logic       overflow
);

  localparam logic [3:0] MAX_MIN_T = 4'(MAX_MIN / 10);
  localparam logic [3:0] MAX_MIN_U = 4'(MAX_MIN % 10);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_LAP   = 2'd2,
    S_PAUSE = 2'd3
  } state_e;

  // Digit-wise BCD increment of {min_t,min_u,sec_t,sec_u,cs_t,cs_u}.
  // Bit 24 of the result flags the wrap past MAX_MIN:59.99.
  function automatic logic [24:0] bcd_inc(input logic [23:0] cnt);
    logic [3:0] mt, mu, st, su, ct, cu;
    logic       wrap;
    {mt, mu, st, su, ct, cu} = cnt;
    wrap = 1'b0;
    if (cu != 4'd9) begin
      cu = cu + 4'd1;
    end else begin
      cu = 4'd0;
      if (ct != 4'd9) begin
        ct = ct + 4'd1;
      end else begin
        ct = 4'd0;
        if (su != 4'd9) begin
          su = su + 4'd1;
        end else begin
          su = 4'd0;
          if (st != 4'd5) begin
            st = st + 4'd1;
          end else begin
            st = 4'd0;
            if ((mt == MAX_MIN_T) && (mu == MAX_MIN_U)) begin
              mt   = 4'd0;
              mu   = 4'd0;
              wrap = 1'b1;
            end else if (mu != 4'd9) begin
              mu = mu + 4'd1;
            end else begin
              mu = 4'd0;
              mt = mt + 4'd1;
            end
          end
        end
      end
    end
    return {wrap, mt, mu, st, su, ct, cu};
  endfunction

  logic [SYNC_STAGES-1:0] clk_sync_q, start_sync_q, lap_sync_q;
  logic                   clk_hist_q, start_hist_q, lap_hist_q;
  logic                   tick_s, start_p_s, lap_p_s, count_en_s;
  logic [24:0]            inc_s;

  state_e      state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic [23:0] disp_q, disp_d;
  logic        ovf_q, ovf_d;
  logic        work_q, work_d;
  logic        lap_q, lap_d;

  // Synchronise the asynchronous inputs; idle level of all three is 1.
  always_ff @(posedge clk_50) begin
    if (!reset) begin
      clk_sync_q   <= '1;
      start_sync_q <= '1;
      lap_sync_q   <= '1;
      clk_hist_q   <= 1'b1;
      start_hist_q <= 1'b1;
      lap_hist_q   <= 1'b1;
    end else begin
      clk_sync_q   <= {clk_sync_q[SYNC_STAGES-2:0], clk_10ms};
      start_sync_q <= {start_sync_q[SYNC_STAGES-2:0], key_start_n};
      lap_sync_q   <= {lap_sync_q[SYNC_STAGES-2:0], key_lap_n};
      clk_hist_q   <= clk_sync_q[SYNC_STAGES-1];
      start_hist_q <= start_sync_q[SYNC_STAGES-1];
      lap_hist_q   <= lap_sync_q[SYNC_STAGES-1];
    end
  end

  assign tick_s     = clk_sync_q[SYNC_STAGES-1] & ~clk_hist_q;
  assign start_p_s  = ~start_sync_q[SYNC_STAGES-1] & start_hist_q;
  assign lap_p_s    = ~lap_sync_q[SYNC_STAGES-1] & lap_hist_q;
  assign count_en_s = tick_s & ((state_q == S_RUN) | (state_q == S_LAP));
  assign inc_s      = bcd_inc(cnt_q);

  // Next state, counter and display values; tick is judged on the old state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (count_en_s) begin
      cnt_d = inc_s[23:0];
      ovf_d = ovf_q | inc_s[24];
    end else begin
      cnt_d = cnt_q;
    end
    case (state_q)
      S_IDLE: begin
        cnt_d = 24'd0;
        ovf_d = 1'b0;
        if (start_p_s) begin
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (start_p_s) begin
          state_d = S_PAUSE;
        end else if (lap_p_s) begin
          state_d = S_LAP;
        end else begin
          state_d = S_RUN;
        end
      end
      S_LAP: begin
        if (start_p_s) begin
          state_d = S_PAUSE;
        end else if (lap_p_s) begin
          state_d = S_RUN;
        end else begin
          state_d = S_LAP;
        end
      end
      S_PAUSE: begin
        if (start_p_s) begin
          state_d = S_RUN;
        end else if (lap_p_s) begin
          state_d = S_IDLE;
          cnt_d   = 24'd0;
          ovf_d   = 1'b0;
        end else begin
          state_d = S_PAUSE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 24'd0;
        ovf_d   = 1'b0;
      end
    endcase
    // While in LAP the display keeps what it showed when the lap was taken.
    disp_d = (state_d == S_LAP) ? disp_q : cnt_d;
    work_d = (state_d == S_RUN) | (state_d == S_LAP);
    lap_d  = (state_d == S_LAP);
  end

  // State, counter and output registers.
  always_ff @(posedge clk_50) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 24'd0;
      disp_q  <= 24'd0;
      ovf_q   <= 1'b0;
      work_q  <= 1'b0;
      lap_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
      ovf_q   <= ovf_d;
      work_q  <= work_d;
      lap_q   <= lap_d;
    end
  end

  assign work       = work_q;
  assign min_bcd    = disp_q[23:16];
  assign sec_bcd    = disp_q[15:8];
  assign cs_bcd     = disp_q[7:0];
  assign lap_active = lap_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_stopwatch_time_core.sv
// Directed bench for stopwatch_time_core. MAX_MIN is set to 1 so the
// minute wrap is reachable in a short run; ticks use a fast clk_10ms.
module tb_stopwatch_time_core;

  localparam int TB_MAX_MIN = 1;
  localparam int WRAP_T     = (TB_MAX_MIN + 1) * 6000;

  logic       clk_50;
  logic       reset;
  logic       clk_10ms;
  logic       key_start_n;
  logic       key_lap_n;
  logic       work;
  logic [7:0] cs_bcd, sec_bcd, min_bcd;
  logic       lap_active;
  logic       overflow;
  logic [23:0] disp;

  int n_checks;
  int n_fail;
  int model_t;

  stopwatch_time_core #(.SYNC_STAGES(2), .MAX_MIN(TB_MAX_MIN)) dut (
    .clk_50      (clk_50),
    .reset       (reset),
    .clk_10ms    (clk_10ms),
    .key_start_n (key_start_n),
    .key_lap_n   (key_lap_n),
    .work        (work),
    .cs_bcd      (cs_bcd),
    .sec_bcd     (sec_bcd),
    .min_bcd     (min_bcd),
    .lap_active  (lap_active),
    .overflow    (overflow)
  );

  assign disp = {min_bcd, sec_bcd, cs_bcd};

  initial clk_50 = 1'b0;
  always #10 clk_50 = ~clk_50;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] to_bcd(input int t);
    int cs, s, m;
    cs = t % 100;
    s  = (t / 100) % 60;
    m  = t / 6000;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(cs / 10), 4'(cs % 10)};
  endfunction

  task automatic model_tick();
    model_t++;
    if (model_t == WRAP_T) model_t = 0;
  endtask

  // Press and release keys; returns #1 after the edge where the event lands.
  task automatic press(input bit s, input bit l);
    @(negedge clk_50);
    key_start_n = ~s;
    key_lap_n   = ~l;
    repeat (3) @(posedge clk_50);
    #1;
    @(negedge clk_50);
    key_start_n = 1'b1;
    key_lap_n   = 1'b1;
    repeat (4) @(posedge clk_50);
    #1;
  endtask

  // Two-cycle clk_10ms periods; counted says whether the model advances.
  task automatic fast_ticks(input int n, input bit counted);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_50);
      clk_10ms = 1'b0;
      @(negedge clk_50);
      clk_10ms = 1'b1;
      if (counted) model_tick();
    end
    repeat (4) @(posedge clk_50);
    #1;
  endtask

  // One long-period tick with the update edge and the high phase checked.
  task automatic slow_tick();
    @(negedge clk_50);
    clk_10ms = 1'b0;
    repeat (3) @(negedge clk_50);
    clk_10ms = 1'b1;
    @(posedge clk_50); #1;
    check_value("lat_e1", 32'(disp), 32'(to_bcd(model_t)));
    @(posedge clk_50); #1;
    check_value("lat_e2", 32'(disp), 32'(to_bcd(model_t)));
    @(posedge clk_50); #1;
    model_tick();
    check_value("lat_e3", 32'(disp), 32'(to_bcd(model_t)));
    repeat (8) @(posedge clk_50);
    #1;
    check_value("hold_high", 32'(disp), 32'(to_bcd(model_t)));
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    model_t     = 0;
    reset       = 1'b0;
    clk_10ms    = 1'b1;
    key_start_n = 1'b1;
    key_lap_n   = 1'b1;
    repeat (3) @(posedge clk_50);
    @(negedge clk_50);
    reset = 1'b1;
    repeat (2) @(posedge clk_50);
    #1;
    check_value("rst_disp", 32'(disp), 32'h0);
    check_value("rst_work", 32'(work), 32'h0);
    check_value("rst_lap", 32'(lap_active), 32'h0);
    check_value("rst_ovf", 32'(overflow), 32'h0);

    // Start/stop sequence with no timebase edges.
    for (int i = 0; i < 5; i++) begin
      press(1'b1, 1'b0);
      check_value("ss_work", 32'(work), (i % 2 == 0) ? 32'h1 : 32'h0);
      check_value("ss_disp", 32'(disp), 32'h0);
    end

    // 150 long-period ticks in RUN.
    for (int i = 0; i < 150; i++) slow_tick();
    check_value("t150", 32'(disp), 32'h000150);

    // Lap freeze at 00:12.34, 100 more ticks, lap release.
    fast_ticks(1234 - model_t, 1'b1);
    check_value("pre_lap", 32'(disp), 32'h001234);
    press(1'b0, 1'b1);
    check_value("lap_on", 32'(lap_active), 32'h1);
    fast_ticks(100, 1'b1);
    check_value("lap_hold", 32'(disp), 32'h001234);
    check_value("lap_work", 32'(work), 32'h1);
    press(1'b0, 1'b1);
    check_value("lap_off", 32'(lap_active), 32'h0);
    check_value("lap_live", 32'(disp), 32'h001334);

    // Start+lap together with a coincident tick while RUN.
    @(negedge clk_50);
    clk_10ms = 1'b0;
    repeat (3) @(negedge clk_50);
    clk_10ms    = 1'b1;
    key_start_n = 1'b0;
    key_lap_n   = 1'b0;
    repeat (3) @(posedge clk_50);
    #1;
    model_tick();
    check_value("coinc_disp", 32'(disp), 32'h001335);
    check_value("coinc_work", 32'(work), 32'h0);
    check_value("coinc_lap", 32'(lap_active), 32'h0);
    @(negedge clk_50);
    key_start_n = 1'b1;
    key_lap_n   = 1'b1;
    fast_ticks(1, 1'b0);
    check_value("pause_drop", 32'(disp), 32'h001335);

    // Wrap past 1:59.99 sets overflow; PAUSE->IDLE clears everything.
    press(1'b1, 1'b0);
    check_value("resume", 32'(work), 32'h1);
    fast_ticks(11999 - model_t, 1'b1);
    check_value("pre_wrap", 32'(disp), 32'h015999);
    check_value("pre_ovf", 32'(overflow), 32'h0);
    fast_ticks(1, 1'b1);
    check_value("wrap_disp", 32'(disp), 32'h000000);
    check_value("wrap_ovf", 32'(overflow), 32'h1);
    fast_ticks(1, 1'b1);
    check_value("post_disp", 32'(disp), 32'h000001);
    check_value("post_ovf", 32'(overflow), 32'h1);
    press(1'b1, 1'b0);
    check_value("pause_work", 32'(work), 32'h0);
    press(1'b0, 1'b1);
    model_t = 0;
    check_value("clr_disp", 32'(disp), 32'h0);
    check_value("clr_ovf", 32'(overflow), 32'h0);
    check_value("clr_work", 32'(work), 32'h0);
    fast_ticks(1, 1'b0);
    check_value("idle_drop", 32'(disp), 32'h0);

    // Reset while in LAP at 01:21.07.
    press(1'b1, 1'b0);
    check_value("run2_work", 32'(work), 32'h1);
    fast_ticks(8107, 1'b1);
    check_value("t012107", 32'(disp), 32'h012107);
    press(1'b0, 1'b1);
    fast_ticks(5, 1'b1);
    check_value("lap2_hold", 32'(disp), 32'h012107);
    @(negedge clk_50);
    reset = 1'b0;
    @(posedge clk_50); #1;
    check_value("mid_rst_disp", 32'(disp), 32'h0);
    check_value("mid_rst_work", 32'(work), 32'h0);
    check_value("mid_rst_lap", 32'(lap_active), 32'h0);
    @(negedge clk_50);
    reset = 1'b1;
    press(1'b1, 1'b0);
    check_value("run3_work", 32'(work), 32'h1);
    repeat (10) @(posedge clk_50);
    #1;
    check_value("no_tick_high", 32'(disp), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
